// File: rtl/slave_mem_responder_if.sv
// Request/ack bus between a crossbar master port and a memory-backed slave.
interface slave_mem_responder_if;
  logic        req;
  logic        cmd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        busy;

  modport master (output req, cmd, addr, wdata, input ack, rdata, busy);
  modport slave  (input req, cmd, addr, wdata, output ack, rdata, busy);
endinterface

// File: rtl/slave_mem_responder.sv
// Word-array slave: captures a request, waits LATENCY cycles, pulses ack and,
// for reads, drives rdata for one cycle. rdata is zero otherwise so buses can OR.
module slave_mem_responder #(
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  slave_mem_responder_if.slave  bus
);

  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "slave_mem_responder: LATENCY must be 0..15");
  end
  if (AW < 1 || AW > 29) begin : g_bad_aw
    $fatal(1, "slave_mem_responder: AW must be 1..29");
  end

  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, DATA} state_t;

  state_t          state, state_nx;
  logic [3:0]      cnt, cnt_nx;
  logic            cmd_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [2**AW];

  // Byte offset and bits above the word index only alias; they never select.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      cmd_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && bus.req) begin
        cmd_q   <= bus.cmd;
        idx_q   <= bus.addr[AW+1:2];
        wdata_q <= bus.wdata;
      end
      if (state == ACK && !cmd_q)
        rdata_q <= mem[idx_q];
    end
  end

  // Storage is deliberately not reset; the write strobe depends on state,
  // which async reset forces out of ACK, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (state == ACK && cmd_q)
      mem[idx_q] <= wdata_q;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (bus.req) begin
        if (LATENCY == 0) state_nx = ACK;
        else begin
          state_nx = WAIT;
          cnt_nx   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nx = ACK;
        else             cnt_nx   = cnt - 4'd1;
      end
      ACK:     state_nx = cmd_q ? IDLE : DATA;
      DATA:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.ack   = (state == ACK);
  assign bus.busy  = (state != IDLE);
  assign bus.rdata = (state == DATA) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_slave_mem_responder.sv
// Three responders (LATENCY 2, 0, 1); directed transactions push expected acks
// into a scoreboard that a negedge monitor pops and checks.
module tb_slave_mem_responder;

  logic        clk = 1'b0;
  logic [2:0]  rst = 3'b111;
  logic [2:0]  req_d = '0, cmd_d = '0;
  logic [31:0] addr_d [3];
  logic [31:0] wdata_d [3];
  logic [2:0]  ack_o, busy_o;
  logic [31:0] rdata_o [3];

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    slave_mem_responder_if bus ();
    assign bus.req    = req_d[g];
    assign bus.cmd    = cmd_d[g];
    assign bus.addr   = addr_d[g];
    assign bus.wdata  = wdata_d[g];
    assign ack_o[g]   = bus.ack;
    assign busy_o[g]  = bus.busy;
    assign rdata_o[g] = bus.rdata;
    slave_mem_responder #(.AW(8), .LATENCY(g == 0 ? 2 : (g == 1 ? 0 : 1))) dut (
      .clk   (clk),
      .reset (rst[g]),
      .bus   (bus.slave)
    );
  end

  typedef struct {
    int          d;
    longint      ack_cyc;
    bit          cmd;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests = 0, fails = 0;
  bit          mon_en = 0;
  bit          rd_pend [3] = '{0, 0, 0};
  longint      rd_cyc [3];
  logic [31:0] rd_exp [3];

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, want %h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every ack must match the head of the scoreboard in dut and cycle;
  // rdata must be zero except in the cycle right after a read ack.
  always @(negedge clk) if (mon_en) begin
    for (int d = 0; d < 3; d++) begin
      logic [31:0] want;
      if (ack_o[d]) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_ack: dut%0d acked at cyc %0d, none expected", d, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.d != d || mon_e.ack_cyc != cyc) begin
            fails++;
            $display("FAIL ack_timing: got dut%0d cyc %0d, want dut%0d cyc %0d",
                     d, cyc, mon_e.d, mon_e.ack_cyc);
          end
          if (!mon_e.cmd) begin
            rd_pend[mon_e.d] = 1;
            rd_cyc[mon_e.d]  = mon_e.ack_cyc + 1;
            rd_exp[mon_e.d]  = mon_e.rd;
          end
        end
      end
      want = (rd_pend[d] && cyc == rd_cyc[d]) ? rd_exp[d] : 32'h0;
      if (rd_pend[d] && cyc == rd_cyc[d]) rd_pend[d] = 0;
      tests++;
      if (rdata_o[d] !== want) begin
        fails++;
        $display("FAIL rdata_dut%0d: got %h, want %h (cyc %0d)", d, rdata_o[d], want, cyc);
      end
    end
  end

  task automatic do_txn(input int d, input bit c, input logic [31:0] a,
                        input logic [31:0] w, input logic [31:0] r);
    longint s;
    bit     got;
    @(negedge clk);
    req_d[d] = 1'b1; cmd_d[d] = c; addr_d[d] = a; wdata_d[d] = w;
    s = cyc + 1;
    sb.push_back('{d: d, ack_cyc: s + lat_of(d), cmd: c, rd: r});
    @(negedge clk);
    check("busy_after_capture", {31'b0, busy_o[d]}, 32'd1);
    got = ack_o[d];
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = ack_o[d];
    end
    req_d[d] = 1'b0;
    if (!got) begin
      tests++; fails++;
      $display("FAIL ack_timeout: dut%0d no ack within bound (cyc %0d)", d, cyc);
    end
    repeat (c ? 1 : 2) @(negedge clk);
    check("busy_back_idle", {31'b0, busy_o[d]}, 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      addr_d[d] = 32'h0; wdata_d[d] = 32'h0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset_ack",   {31'b0, ack_o[d]},  32'd0);
      check("reset_busy",  {31'b0, busy_o[d]}, 32'd0);
      check("reset_rdata", rdata_o[d],         32'h0);
    end
    rst = 3'b000;
    mon_en = 1;

    // LATENCY=2: write then read-back, alias through addr[31] and bit 10
    do_txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
    do_txn(0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF);
    do_txn(0, 1'b1, 32'h8000_0404, 32'h1234_5678, 32'h0);
    do_txn(0, 1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678);
    do_txn(0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF);

    // LATENCY=0 pair
    do_txn(1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0);
    do_txn(1, 1'b0, 32'h0000_0020, 32'h0,         32'hCAFE_F00D);
    do_txn(1, 1'b0, 32'hFFFF_FC20, 32'h0,         32'hCAFE_F00D);

    // Reset during WAIT must discard the pending write
    do_txn(0, 1'b1, 32'h0000_0040, 32'h5555_5555, 32'h0);
    @(negedge clk);
    req_d[0] = 1'b1; cmd_d[0] = 1'b1; addr_d[0] = 32'h40; wdata_d[0] = 32'hAAAA_AAAA;
    @(negedge clk);
    rst[0] = 1'b1;
    req_d[0] = 1'b0;
    #1;
    check("midop_reset_busy", {31'b0, busy_o[0]}, 32'd0);
    check("midop_reset_ack",  {31'b0, ack_o[0]},  32'd0);
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    do_txn(0, 1'b0, 32'h0000_0040, 32'h0, 32'h5555_5555);

    // LATENCY=1, req held 12 cycles: three back-to-back reads
    do_txn(2, 1'b1, 32'h0000_0080, 32'h0BAD_F00D, 32'h0);
    @(negedge clk);
    req_d[2] = 1'b1; cmd_d[2] = 1'b0; addr_d[2] = 32'h80;
    begin
      longint s;
      s = cyc + 1;
      for (int k = 0; k < 3; k++)
        sb.push_back('{d: 2, ack_cyc: s + 1 + 4 * k, cmd: 1'b0, rd: 32'h0BAD_F00D});
    end
    repeat (12) @(negedge clk);
    req_d[2] = 1'b0;

    repeat (6) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    check("reads_delivered", {29'b0, rd_pend[0], rd_pend[1], rd_pend[2]}, 32'd0);
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
